// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Two-port data-memory arbiter and access sequencer. Shares one data-memory
//   port between the CPU MEM stage (port 0) and the DMA/bridge master (port 1).
//   For each granted request it registers the request fields and checks
//   alignment. It then drives a word-addressed memory access with byte
//   enables and lane-replicated store data, waits for mem_ack, and returns
//   an ack pulse or an err pulse to the winner.
//
//   Configuration macro: DM_ARB_CPU_PRIORITY_EN
//     undefined (default): round-robin arbitration on ties.
//     defined            : fixed priority, so the CPU always wins a tie.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   cpu_* / dma_*         request side: req, we, addr, size, wdata in;
//                         ack, err pulses and raw read word out
//   mem_*                 memory side: req, we, word addr, be, wdata out;
//                         rdata, ack in
//   busy                  FSM is not in IDLE
module dm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_size,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [1:0]    dma_size,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_gnt_dma;      // 1 = current access belongs to the DMA port
`ifndef DM_ARB_CPU_PRIORITY_EN
    logic          r_last;         // 1 = DMA was granted last
`endif
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic [DW-1:0] r_wdata;
    logic          r_bad;
    logic          r_cpu_ack, r_dma_ack, r_cpu_err, r_dma_err;
    logic [DW-1:0] r_cpu_rdata, r_dma_rdata;
    logic          r_mem_req, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [DW-1:0] r_mem_wdata;

    logic          w_any;
    logic          w_gnt_dma;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [1:0]    w_sel_size;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_bad;
    logic [3:0]    w_be;
    logic [DW-1:0] w_lane_wdata;

    // Winner selection and alignment check on the incoming request.
    always_comb begin
        w_any = cpu_req | dma_req;
`ifdef DM_ARB_CPU_PRIORITY_EN
        w_gnt_dma = ~cpu_req;
`else
        w_gnt_dma = dma_req & (~cpu_req | ~r_last);
`endif
        w_sel_we    = w_gnt_dma ? dma_we    : cpu_we;
        w_sel_addr  = w_gnt_dma ? dma_addr  : cpu_addr;
        w_sel_size  = w_gnt_dma ? dma_size  : cpu_size;
        w_sel_wdata = w_gnt_dma ? dma_wdata : cpu_wdata;
        case (w_sel_size)
            2'd0:    w_sel_bad = (w_sel_addr[1:0] != 2'b00);
            2'd1:    w_sel_bad = w_sel_addr[0];
            2'd2:    w_sel_bad = 1'b0;
            default: w_sel_bad = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data from the registered request.
    always_comb begin
        case (r_size)
            2'd0: begin
                w_be         = 4'b1111;
                w_lane_wdata = r_wdata;
            end
            2'd1: begin
                w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_wdata = {2{r_wdata[15:0]}};
            end
            2'd2: begin
                w_be         = 4'b0001 << r_addr[1:0];
                w_lane_wdata = {4{r_wdata[7:0]}};
            end
            default: begin
                w_be         = '0;
                w_lane_wdata = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt_dma   <= 1'b0;
`ifndef DM_ARB_CPU_PRIORITY_EN
            r_last      <= 1'b1;
`endif
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_bad       <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dma_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            r_dma_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_dma <= w_gnt_dma;
`ifndef DM_ARB_CPU_PRIORITY_EN
                        r_last    <= w_gnt_dma;
`endif
                        r_we      <= w_sel_we;
                        r_addr    <= w_sel_addr;
                        r_size    <= w_sel_size;
                        r_wdata   <= w_sel_wdata;
                        r_bad     <= w_sel_bad;
                        // The check result is registered at grant so the err
                        // pulse is visible during the CHECK cycle itself.
                        r_cpu_err <= w_sel_bad & ~w_gnt_dma;
                        r_dma_err <= w_sel_bad &  w_gnt_dma;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_bad) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= r_we;
                        r_mem_addr  <= {r_addr[AW-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_lane_wdata;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (r_gnt_dma) r_dma_rdata <= mem_rdata;
                        else           r_cpu_rdata <= mem_rdata;
                        r_cpu_ack <= ~r_gnt_dma;
                        r_dma_ack <=  r_gnt_dma;
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign dma_ack   = r_dma_ack;
    assign cpu_err   = r_cpu_err;
    assign dma_err   = r_dma_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
    logic [1:0]  cpu_size, dma_size;
    logic        cpu_ack, cpu_err, dma_ack, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata [2];   // expected held read word per port

    always #5 clk = ~clk;

    dm_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_size(dma_size),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    // Drives one request on one port from IDLE and plays the memory side.
    // Cycle 1 is the cycle right after the edge that samples the request.
    // Returns what was observed; cycle numbers are -1 when never seen.
    task automatic run_access(input bit port, input logic we, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] wdata,
                              input int mdelay, input logic [31:0] rd,
                              output int err_cyc, output int req_cyc, output int ack_cyc,
                              output logic o_we, output logic [31:0] o_addr,
                              output logic [3:0] o_be, output logic [31:0] o_wdata,
                              output logic [31:0] o_rdata, output bit unstable,
                              output bit stray);
        logic own_ack, own_err;
        err_cyc = -1; req_cyc = -1; ack_cyc = -1;
        o_we = 1'b0; o_addr = '0; o_be = '0; o_wdata = '0; o_rdata = '0;
        unstable = 1'b0; stray = 1'b0;
        if (port) begin
            dma_we = we; dma_addr = addr; dma_size = size; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_size = size; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                if (req_cyc < 0) begin
                    req_cyc = cyc; o_we = mem_we; o_addr = mem_addr;
                    o_be = mem_be; o_wdata = mem_wdata;
                end else if (o_we !== mem_we || o_addr !== mem_addr ||
                             o_be !== mem_be || o_wdata !== mem_wdata) begin
                    unstable = 1'b1;
                end
                mem_ack   = (cyc - req_cyc == mdelay);
                mem_rdata = mem_ack ? rd : ~rd;
            end else begin
                mem_ack = 1'b0;
            end
            own_ack = port ? dma_ack : cpu_ack;
            own_err = port ? dma_err : cpu_err;
            if ((port ? cpu_ack : dma_ack) || (port ? cpu_err : dma_err)) stray = 1'b1;
            if (own_err && err_cyc < 0) err_cyc = cyc;
            if (own_ack && ack_cyc < 0) begin
                ack_cyc = cyc;
                o_rdata = port ? dma_rdata : cpu_rdata;
            end
            if (own_ack || own_err) break;
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({cpu_ack, dma_ack, cpu_err, dma_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {cpu_ack, dma_ack, cpu_err, dma_err});
        end
        n_tests++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mem got req=%b we=%b be=%b addr=%h wdata=%h exp all 0",
                               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({cpu_rdata, dma_rdata, busy} !== '0) begin
            n_fail++; $display("FAIL reset_rdata_busy got cpu=%h dma=%h busy=%b exp 0",
                               cpu_rdata, dma_rdata, busy);
        end
        reset = 1'b0;
        // Stray mem_ack while idle must be ignored.
        mem_ack = 1'b1; bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (cpu_ack || dma_ack || busy || mem_req) bad = 1'b1;
        end
        mem_ack = 1'b0;
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL idle_mem_ack_ignored got=%b exp=0", bad);
        end
        exp_rdata[0] = '0; exp_rdata[1] = '0;
    endtask

    task automatic test_cpu_sb();
        int e, r, a; logic w; logic [31:0] ad, wd, rd; logic [3:0] be; bit u, s;
        run_access(1'b0, 1'b1, 32'h0000_0013, 2'd2, 32'h0000_00A5, 0, 32'h0, e, r, a, w, ad, be, wd, rd, u, s);
        exp_rdata[0] = 32'h0;
        n_tests++;
        if (r !== 2 || a !== 3 || e !== -1) begin
            n_fail++; $display("FAIL sb_latency got req=%0d ack=%0d err=%0d exp 2/3/-1", r, a, e);
        end
        n_tests++;
        if (ad !== 32'h10 || be !== 4'b1000 || wd !== 32'hA5A5A5A5 || w !== 1'b1) begin
            n_fail++; $display("FAIL sb_fields got addr=%h be=%b wdata=%h we=%b exp 10/1000/a5a5a5a5/1",
                               ad, be, wd, w);
        end
        n_tests++;
        if (u !== 1'b0 || s !== 1'b0) begin
            n_fail++; $display("FAIL sb_stable got unstable=%b stray=%b exp 0/0", u, s);
        end
    endtask

    task automatic test_dma();
        int e, r, a; logic w; logic [31:0] ad, wd, rd; logic [3:0] be; bit u, s;
        run_access(1'b1, 1'b1, 32'h0000_0022, 2'd1, 32'h0000_BEEF, 0, 32'h0, e, r, a, w, ad, be, wd, rd, u, s);
        exp_rdata[1] = 32'h0;
        n_tests++;
        if (be !== 4'b1100 || wd !== 32'hBEEFBEEF || ad !== 32'h20 || a !== 3) begin
            n_fail++; $display("FAIL dma_sh got be=%b wdata=%h addr=%h ack=%0d exp 1100/beefbeef/20/3",
                               be, wd, ad, a);
        end
        run_access(1'b1, 1'b0, 32'h0000_0024, 2'd0, 32'h0, 4, 32'h12345678, e, r, a, w, ad, be, wd, rd, u, s);
        exp_rdata[1] = 32'h12345678;
        n_tests++;
        if (r !== 2 || a !== 7 || rd !== 32'h12345678) begin
            n_fail++; $display("FAIL dma_lw_delay got req=%0d ack=%0d rdata=%h exp 2/7/12345678", r, a, rd);
        end
        n_tests++;
        if (be !== 4'b1111 || w !== 1'b0 || ad !== 32'h24 || u !== 1'b0) begin
            n_fail++; $display("FAIL dma_lw_fields got be=%b we=%b addr=%h unstable=%b exp 1111/0/24/0",
                               be, w, ad, u);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dma_rdata !== exp_rdata[1] || cpu_rdata !== exp_rdata[0]) begin
            n_fail++; $display("FAIL rdata_hold got dma=%h cpu=%h exp %h/%h",
                               dma_rdata, cpu_rdata, exp_rdata[1], exp_rdata[0]);
        end
    endtask

    task automatic test_err();
        int e, r, a; logic w; logic [31:0] ad, wd, rd; logic [3:0] be; bit u, s;
        run_access(1'b0, 1'b1, 32'h0000_0006, 2'd0, 32'h1, 0, 32'h0, e, r, a, w, ad, be, wd, rd, u, s);
        n_tests++;
        if (e !== 1 || r !== -1 || a !== -1 || s !== 1'b0) begin
            n_fail++; $display("FAIL err_sw_misaligned got err=%0d req=%0d ack=%0d stray=%b exp 1/-1/-1/0",
                               e, r, a, s);
        end
        run_access(1'b0, 1'b0, 32'h0000_0000, 2'd3, 32'h0, 0, 32'h0, e, r, a, w, ad, be, wd, rd, u, s);
        n_tests++;
        if (e !== 1 || r !== -1 || a !== -1) begin
            n_fail++; $display("FAIL err_size3 got err=%0d req=%0d ack=%0d exp 1/-1/-1", e, r, a);
        end
    endtask

    task automatic test_rr();
        int got[$]; int exp_p; bit overlap;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        overlap = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_size = 2'd0;
        dma_we = 1'b0; dma_addr = 32'h200; dma_size = 2'd0;
        mem_rdata = 32'h7654_3210;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (cpu_ack && dma_ack) overlap = 1'b1;
            if (cpu_ack) begin got.push_back(0); exp_rdata[0] = 32'h7654_3210; end
            if (dma_ack) begin got.push_back(1); exp_rdata[1] = 32'h7654_3210; end
            mem_ack = mem_req;
            if (got.size() >= 4) break;
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (got.size() !== 4 || overlap !== 1'b0) begin
            n_fail++; $display("FAIL rr_count got grants=%0d overlap=%b exp 4/0", got.size(), overlap);
        end
        for (int i = 0; i < got.size(); i++) begin
`ifdef DM_ARB_CPU_PRIORITY_EN
            exp_p = 0;
`else
            exp_p = i % 2;
`endif
            n_tests++;
            if (got[i] !== exp_p) begin
                n_fail++; $display("FAIL rr_order[%0d] got port=%0d exp port=%0d", i, got[i], exp_p);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e, r, a; logic w; logic [31:0] ad, wd, rd; logic [3:0] be; bit u, s;
        bit found, bad;
        found = 1'b0; bad = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h40; cpu_size = 2'd0; mem_ack = 1'b0;
        cpu_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (mem_req) begin found = 1'b1; break; end
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_reach_access got=%b exp=1", found);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || {cpu_ack, cpu_err, dma_ack, dma_err} !== 4'b0) begin
            n_fail++; $display("FAIL rst_mid_abort got mem_req=%b busy=%b pulses=%b exp 0/0/0000",
                               mem_req, busy, {cpu_ack, cpu_err, dma_ack, dma_err});
        end
        reset = 1'b0; cpu_req = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ack || cpu_err || dma_ack || dma_err || mem_req) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_response got=%b exp=0", bad);
        end
        run_access(1'b1, 1'b0, 32'h80, 2'd0, 32'h0, 2, 32'hCAFEF00D, e, r, a, w, ad, be, wd, rd, u, s);
        exp_rdata[1] = 32'hCAFEF00D;
        n_tests++;
        if (a !== 5 || rd !== 32'hCAFEF00D || ad !== 32'h80 || e !== -1) begin
            n_fail++; $display("FAIL rst_mid_dma_after got ack=%0d rdata=%h addr=%h err=%0d exp 5/cafef00d/80/-1",
                               a, rd, ad, e);
        end
    endtask

    task automatic test_random();
        int e, r, a; logic w; logic [31:0] ad, wd, rd; logic [3:0] be; bit u, s;
        bit port, bad; logic we; logic [31:0] addr, wdata, rdv, exp_wd; logic [1:0] size;
        int dly, nb, sh; logic [3:0] exp_be;
        for (int it = 0; it < 30; it++) begin
            port  = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom & 32'h0000_0FFF;
            wdata = $urandom;
            rdv   = $urandom;
            dly   = int'($urandom_range(0, 3));
            bad   = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd0 && addr % 4 != 0);
            run_access(port, we, addr, size, wdata, dly, rdv, e, r, a, w, ad, be, wd, rd, u, s);
            if (bad) begin
                n_tests++;
                if (e !== 1 || r !== -1 || a !== -1 || s !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_err[%0d] addr=%h size=%0d got err=%0d req=%0d ack=%0d exp 1/-1/-1",
                                       it, addr, size, e, r, a);
                end
            end else begin
                nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
                sh = int'(addr % 4);
                exp_be = 4'(((1 << nb) - 1) << sh);
                exp_wd = (size == 2'd0) ? wdata :
                         (size == 2'd1) ? (wdata & 32'h0000_FFFF) * 32'h0001_0001 :
                                          (wdata & 32'h0000_00FF) * 32'h0101_0101;
                exp_rdata[port] = rdv;
                n_tests++;
                if (r !== 2 || a !== 3 + dly || e !== -1 || u !== 1'b0 || s !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_timing[%0d] got req=%0d ack=%0d err=%0d unst=%b stray=%b exp 2/%0d/-1/0/0",
                                       it, r, a, e, u, s, 3 + dly);
                end
                n_tests++;
                if (ad !== addr - (addr % 4) || be !== exp_be || wd !== exp_wd || w !== we) begin
                    n_fail++; $display("FAIL rnd_fields[%0d] got addr=%h be=%b wd=%h we=%b exp %h/%b/%h/%b",
                                       it, ad, be, wd, w, addr - (addr % 4), exp_be, exp_wd, we);
                end
                n_tests++;
                if (rd !== rdv) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, rd, rdv);
                end
            end
            n_tests++;
            if (cpu_rdata !== exp_rdata[0] || dma_rdata !== exp_rdata[1]) begin
                n_fail++; $display("FAIL rnd_hold[%0d] got cpu=%h dma=%h exp %h/%h",
                                   it, cpu_rdata, dma_rdata, exp_rdata[0], exp_rdata[1]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_size = '0; dma_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_cpu_sb();
        test_dma();
        test_err();
        test_random();
        test_rr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
